// File: rtl/ifetch_rsp_arb.sv
// ifetch_rsp_arb: round-robin merge of NUM_REQS instruction-fetch response
// streams into one registered ifetch response stream.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   in_valid/in_ready  per-input handshake (at most one ready bit set)
//   in_uuid/tmask/wid/PC/data  packed per-input payloads, input i in slice i
//   out_valid/out_ready        output handshake
//   out_uuid/tmask/wid/PC/data registered output payload
//   out_idx            index of the input that supplied the current output
//
// The output is a single pipeline register. A new response loads whenever
// the register is empty or being drained this cycle, so a continuous stream
// moves at one response per cycle. The round-robin pointer moves only on a
// transfer, so an input that stays valid is served within NUM_REQS transfers.
module ifetch_rsp_arb #(
  parameter int NUM_REQS    = 2,
  parameter int UUID_BITS   = 44,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int REQ_BITS    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             in_valid,
  input  logic [NUM_REQS*UUID_BITS-1:0]   in_uuid,
  input  logic [NUM_REQS*NUM_THREADS-1:0] in_tmask,
  input  logic [NUM_REQS*NW_BITS-1:0]     in_wid,
  input  logic [NUM_REQS*32-1:0]          in_PC,
  input  logic [NUM_REQS*32-1:0]          in_data,
  output logic [NUM_REQS-1:0]             in_ready,
  output logic                            out_valid,
  output logic [UUID_BITS-1:0]            out_uuid,
  output logic [NUM_THREADS-1:0]          out_tmask,
  output logic [NW_BITS-1:0]              out_wid,
  output logic [31:0]                     out_PC,
  output logic [31:0]                     out_data,
  output logic [REQ_BITS-1:0]             out_idx,
  input  logic                            out_ready
);

  logic                   r_valid;
  logic [UUID_BITS-1:0]   r_uuid;
  logic [NUM_THREADS-1:0] r_tmask;
  logic [NW_BITS-1:0]     r_wid;
  logic [31:0]            r_pc;
  logic [31:0]            r_data;
  logic [REQ_BITS-1:0]    r_idx;
  logic [REQ_BITS-1:0]    r_rr_ptr;

  logic                   w_can_accept;
  logic                   w_fire;
  logic [REQ_BITS-1:0]    w_grant;
  logic                   w_grant_valid;
  logic [UUID_BITS-1:0]   w_uuid;
  logic [NUM_THREADS-1:0] w_tmask;
  logic [NW_BITS-1:0]     w_wid;
  logic [31:0]            w_pc;
  logic [31:0]            w_data;

  // The register can take a new response unless it holds one that is blocked.
  assign w_can_accept = ~(r_valid & ~out_ready);
  assign w_fire       = w_can_accept & w_grant_valid;

  generate
    if (NUM_REQS == 1) begin : g_single
      assign w_grant       = '0;
      assign w_grant_valid = in_valid[0];
    end else begin : g_multi
      // Round-robin search starting just after the last granted input.
      // Offsets are scanned high to low so the nearest valid input wins.
      always_comb begin
        int j;
        j             = 0;
        w_grant       = '0;
        w_grant_valid = 1'b0;
        for (int k = NUM_REQS; k >= 1; k--) begin
          j = (int'(r_rr_ptr) + k) % NUM_REQS;
          if (in_valid[j[REQ_BITS-1:0]]) begin
            w_grant       = j[REQ_BITS-1:0];
            w_grant_valid = 1'b1;
          end else begin
            w_grant       = w_grant;
            w_grant_valid = w_grant_valid;
          end
        end
      end
    end
  endgenerate

  // Payload select for the granted input.
  always_comb begin
    w_uuid  = in_uuid[UUID_BITS-1:0];
    w_tmask = in_tmask[NUM_THREADS-1:0];
    w_wid   = in_wid[NW_BITS-1:0];
    w_pc    = in_PC[31:0];
    w_data  = in_data[31:0];
    for (int i = 1; i < NUM_REQS; i++) begin
      if (w_grant == REQ_BITS'(i)) begin
        w_uuid  = in_uuid[i*UUID_BITS +: UUID_BITS];
        w_tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
        w_wid   = in_wid[i*NW_BITS +: NW_BITS];
        w_pc    = in_PC[i*32 +: 32];
        w_data  = in_data[i*32 +: 32];
      end else begin
        w_uuid  = w_uuid;
      end
    end
  end

  // One-hot ready to the granted input; held low while reset is asserted.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_fire && !reset && (w_grant == REQ_BITS'(i))) begin
        in_ready[i] = 1'b1;
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_uuid   <= '0;
      r_tmask  <= '0;
      r_wid    <= '0;
      r_pc     <= 32'h0000_0000;
      r_data   <= 32'h0000_0000;
      r_idx    <= '0;
      r_rr_ptr <= REQ_BITS'(NUM_REQS - 1);
    end else if (w_fire) begin
      r_valid  <= 1'b1;
      r_uuid   <= w_uuid;
      r_tmask  <= w_tmask;
      r_wid    <= w_wid;
      r_pc     <= w_pc;
      r_data   <= w_data;
      r_idx    <= w_grant;
      r_rr_ptr <= w_grant;
    end else if (w_can_accept) begin
      r_valid  <= 1'b0;
    end else begin
      r_valid  <= r_valid;
    end
  end

  assign out_valid = r_valid;
  assign out_uuid  = r_uuid;
  assign out_tmask = r_tmask;
  assign out_wid   = r_wid;
  assign out_PC    = r_pc;
  assign out_data  = r_data;
  assign out_idx   = r_idx;

endmodule
